// File: rtl/sdram_traffic_checker.sv
// ---------------------------------------------------------------------------
// sdram_traffic_checker
//
// User-side self-test engine for sdram_control_top. After a Start pulse it
// clears the controller FIFOs, waits for SDRAM init, pushes NUM_WORDS words
// of the ramp (SEED + i) into the write FIFO, idles DRAIN_CYCLES cycles so
// the controller can flush to SDRAM, then pops the same number of words from
// the read FIFO and checks each one against the ramp.
//
// Ports
//   Clk, Rst_n           : clock, synchronous active-low reset
//   Start                : one-cycle pulse, honoured only in IDLE or DONE
//   Init_done            : SDRAM initialisation complete
//   Wr_full/Wr_en/Wr_data/Wr_load : write-FIFO interface (Wr_load = clear)
//   Rd_empty/Rd_en/Rd_data/Rd_load: read-FIFO interface (non-show-ahead:
//                          Rd_data is valid the cycle after Rd_en)
//   Busy, Done, Pass     : status; Pass is meaningful while Done is high
//   Err_cnt              : saturating mismatch count
//   First_err_idx        : index of first mismatch, 16'hFFFF when none
// ---------------------------------------------------------------------------
module sdram_traffic_checker #(
    parameter int unsigned      DSIZE        = 16,
    parameter int unsigned      NUM_WORDS    = 1000,
    parameter logic [DSIZE-1:0] SEED         = '0,
    parameter int unsigned      DRAIN_CYCLES = 2000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Init_done,
    input  logic             Wr_full,
    output logic             Wr_en,
    output logic [DSIZE-1:0] Wr_data,
    output logic             Wr_load,
    input  logic             Rd_empty,
    output logic             Rd_en,
    input  logic [DSIZE-1:0] Rd_data,
    output logic             Rd_load,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [15:0]      Err_cnt,
    output logic [15:0]      First_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_INIT, S_WRITE, S_DRAIN, S_READ, S_CHECK_TAIL, S_DONE
    } state_e;

    localparam int unsigned    DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [15:0]    LAST_IDX   = 16'(NUM_WORDS);
    localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 1) ? DCW'(DRAIN_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic             load_q, load_d, load_cnt_q;
    logic             wr_en_q;
    logic [DSIZE-1:0] wr_data_q;
    logic [15:0]      wr_idx_q, rd_idx_q, chk_idx_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic             chk_valid_q;
    logic [15:0]      err_cnt_q, first_err_q;
    logic             pass_q;
    logic             start_ok;
    logic             mismatch;

    // Ramp value for a given word index, wrapping at DSIZE bits.
    function automatic logic [DSIZE-1:0] word_at(input logic [15:0] idx);
        return SEED + DSIZE'(idx);
    endfunction

    assign start_ok = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch = chk_valid_q && (Rd_data != word_at(chk_idx_q));

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of block order.
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (Start)                     state_d = S_LOAD;
            S_LOAD:         if (load_cnt_q)                state_d = S_WAIT_INIT;
            S_WAIT_INIT:    if (Init_done)                 state_d = S_WRITE;
            S_WRITE:        if (wr_idx_q == LAST_IDX)      state_d = S_DRAIN;
            S_DRAIN:        if (drain_cnt_q == DRAIN_LAST) state_d = S_READ;
            S_READ:         if (rd_idx_q == LAST_IDX)      state_d = S_CHECK_TAIL;
            S_CHECK_TAIL:                                  state_d = S_DONE;
            default:                                       state_d = S_IDLE;
        endcase
    end

    // Output logic. Rd_en stays combinational so it never pops a FIFO that
    // is empty in the current cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        Busy   = 1'b1;
        Done   = 1'b0;
        Rd_en  = 1'b0;
        load_d = (state_d == S_LOAD);
        case (state_q)
            S_IDLE:  Busy  = 1'b0;
            S_DONE:  begin Busy = 1'b0; Done = 1'b1; end
            S_READ:  Rd_en = !Rd_empty && (rd_idx_q < LAST_IDX);
            default: ;
        endcase
    end

    // Datapath: FIFO strobes, index counters, check pipeline, error registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            load_q      <= 1'b1;
            load_cnt_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            drain_cnt_q <= '0;
            chk_valid_q <= 1'b0;
            chk_idx_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= 16'hFFFF;
            pass_q      <= 1'b0;
        end else begin
            load_q     <= load_d;
            load_cnt_q <= (state_q == S_LOAD) && !load_cnt_q;

            // Push decision registered from this cycle's Wr_full; the index
            // advances on the same edge the push is launched.
            wr_en_q <= 1'b0;
            if (state_q == S_WRITE && !Wr_full && wr_idx_q < LAST_IDX) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= word_at(wr_idx_q);
                wr_idx_q  <= wr_idx_q + 16'd1;
            end

            drain_cnt_q <= (state_q == S_DRAIN && state_d == S_DRAIN) ? drain_cnt_q + 1'b1 : '0;

            if (Rd_en) rd_idx_q <= rd_idx_q + 16'd1;

            // Read data lags Rd_en by one cycle, so the index is delayed too.
            chk_valid_q <= Rd_en;
            chk_idx_q   <= rd_idx_q;

            if (mismatch) begin
                if (err_cnt_q != 16'hFFFF)   err_cnt_q   <= err_cnt_q + 16'd1;
                if (first_err_q == 16'hFFFF) first_err_q <= chk_idx_q;
            end

            if (state_q == S_CHECK_TAIL) pass_q <= (err_cnt_q == 16'd0);

            // Clears come last so they win over any update above.
            if (start_ok) begin
                err_cnt_q   <= '0;
                first_err_q <= 16'hFFFF;
                pass_q      <= 1'b0;
            end
            if (state_q == S_LOAD) begin
                wr_idx_q    <= '0;
                rd_idx_q    <= '0;
                err_cnt_q   <= '0;
                first_err_q <= 16'hFFFF;
            end
        end
    end

    assign Wr_en         = wr_en_q;
    assign Wr_data       = wr_data_q;
    assign Wr_load       = load_q;
    assign Rd_load       = load_q;
    assign Pass          = pass_q;
    assign Err_cnt       = err_cnt_q;
    assign First_err_idx = first_err_q;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// ---------------------------------------------------------------------------
// tb_sdram_traffic_checker
//
// Two checker instances (default ramp, and a short wrapping ramp) share a
// behavioural loopback FIFO: words pushed through Wr_en reappear on the read
// side. Stimulus pushes the expected ramp words and the expected end-of-test
// result into queues; a monitor pops and compares on every push and on every
// rising edge of Done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_traffic_checker;

    localparam int          N0    = 1000;
    localparam int          N1    = 4;
    localparam logic [15:0] SEED1 = 16'hFFFE;

    typedef struct {
        logic [15:0] err;
        logic [15:0] first;
        logic        pass;
        int          n;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, init_done, wr_full, sel;
    logic        rd_empty = 1'b1;
    logic [15:0] rd_data  = '0;
    logic        start0, start1;
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    logic        wr_en0, wr_load0, rd_en0, rd_load0, busy0, done0, pass0;
    logic [15:0] wr_data0, err0, first0;
    logic        wr_en1, wr_load1, rd_en1, rd_load1, busy1, done1, pass1;
    logic [15:0] wr_data1, err1, first1;

    sdram_traffic_checker #(.DSIZE(16), .NUM_WORDS(N0), .SEED(16'h0000), .DRAIN_CYCLES(2000)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .Start(start0), .Init_done(init_done), .Wr_full(wr_full),
        .Wr_en(wr_en0), .Wr_data(wr_data0), .Wr_load(wr_load0), .Rd_empty(rd_empty),
        .Rd_en(rd_en0), .Rd_data(rd_data), .Rd_load(rd_load0), .Busy(busy0), .Done(done0),
        .Pass(pass0), .Err_cnt(err0), .First_err_idx(first0));

    sdram_traffic_checker #(.DSIZE(16), .NUM_WORDS(N1), .SEED(SEED1), .DRAIN_CYCLES(20)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .Start(start1), .Init_done(init_done), .Wr_full(wr_full),
        .Wr_en(wr_en1), .Wr_data(wr_data1), .Wr_load(wr_load1), .Rd_empty(rd_empty),
        .Rd_en(rd_en1), .Rd_data(rd_data), .Rd_load(rd_load1), .Busy(busy1), .Done(done1),
        .Pass(pass1), .Err_cnt(err1), .First_err_idx(first1));

    // Selected instance drives the loopback FIFO and the monitor.
    logic        m_wr_en, m_wr_load, m_rd_en, m_rd_load, m_busy, m_done, m_pass;
    logic [15:0] m_wr_data, m_err, m_first;
    assign m_wr_en   = sel ? wr_en1   : wr_en0;
    assign m_wr_data = sel ? wr_data1 : wr_data0;
    assign m_wr_load = sel ? wr_load1 : wr_load0;
    assign m_rd_en   = sel ? rd_en1   : rd_en0;
    assign m_rd_load = sel ? rd_load1 : rd_load0;
    assign m_busy    = sel ? busy1    : busy0;
    assign m_done    = sel ? done1    : done0;
    assign m_pass    = sel ? pass1    : pass0;
    assign m_err     = sel ? err1     : err0;
    assign m_first   = sel ? first1   : first0;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   mon_pushes = 0;
    int   mon_pops   = 0;
    logic [15:0] exp_wr[$];
    res_t        exp_res[$];
    int          corrupt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] corrupt_mask(input int idx);
        foreach (corrupt[k]) if (corrupt[k] == idx) return 16'h0001;
        return 16'h0000;
    endfunction

    // Loopback FIFO: write side feeds read side, optional bit-0 corruption by
    // push index, optional every-other-cycle Rd_empty.
    logic toggle_en = 1'b0;
    logic phase     = 1'b0;
    logic full_s    = 1'b0;
    int   w_cnt     = 0;
    logic [15:0] fifo_q[$];

    always @(posedge clk) begin
        full_s <= wr_full;
        phase  <= ~phase;
        if (m_wr_load) begin
            fifo_q.delete();
            w_cnt <= 0;
        end else begin
            if (m_wr_en) begin
                fifo_q.push_back(m_wr_data ^ corrupt_mask(w_cnt));
                w_cnt <= w_cnt + 1;
            end
            if (m_rd_en && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
        end
        rd_empty <= (fifo_q.size() == 0) || (toggle_en && phase);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor.
    int   load_len  = 0;
    int   rload_len = 0;
    logic load_busy = 1'b0;
    logic done_prev = 1'b0;

    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (m_wr_load) begin
                mon_pushes = 0;
                mon_pops   = 0;
            end
            if (m_wr_load || m_rd_load) begin
                if (m_wr_load) load_len++;
                if (m_rd_load) rload_len++;
                if (m_busy)    load_busy = 1'b1;
            end else begin
                if (load_busy) begin
                    check("wr_load_len", 32'(load_len), 32'd2);
                    check("rd_load_len", 32'(rload_len), 32'd2);
                end
                load_len = 0; rload_len = 0; load_busy = 1'b0;
            end
            if (m_wr_en) begin
                mon_pushes++;
                check("push_not_full", 32'(full_s), 32'd0);
                if (exp_wr.size() == 0) check("unexpected_push", 32'(m_wr_en), 32'd0);
                else                    check("wr_data", 32'(m_wr_data), 32'(exp_wr.pop_front()));
            end
            if (m_rd_en) begin
                mon_pops++;
                check("pop_not_empty", 32'(rd_empty), 32'd0);
            end
            if (m_done && !done_prev) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_done", 32'(m_done), 32'd0);
                end else begin
                    r = exp_res.pop_front();
                    check("err_cnt",       32'(m_err),      32'(r.err));
                    check("first_err_idx", 32'(m_first),    32'(r.first));
                    check("pass",          32'(m_pass),     32'(r.pass));
                    check("busy_at_done",  32'(m_busy),     32'd0);
                    check("push_count",    32'(mon_pushes), 32'(r.n));
                    check("pop_count",     32'(mon_pops),   32'(r.n));
                end
            end
            done_prev = m_done;
        end
    end

    // Queue the expected ramp and result from the corruption list, then pulse
    // Start for one cycle.
    task automatic issue(input logic [15:0] seed, input int n);
        res_t r;
        r.err = 16'd0; r.first = 16'hFFFF;
        for (int i = 0; i < n; i++) exp_wr.push_back(seed + 16'(i));
        foreach (corrupt[k]) begin
            if (corrupt[k] < n) begin
                r.err++;
                if (16'(corrupt[k]) < r.first) r.first = 16'(corrupt[k]);
            end
        end
        r.pass = (r.err == 16'd0);
        r.n    = n;
        exp_res.push_back(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!m_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", 32'(m_done), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_wr_en",   32'(m_wr_en),   32'd0);
        check("rst_wr_data", 32'(m_wr_data), 32'd0);
        check("rst_wr_load", 32'(m_wr_load), 32'd1);
        check("rst_rd_en",   32'(m_rd_en),   32'd0);
        check("rst_rd_load", 32'(m_rd_load), 32'd1);
        check("rst_busy",    32'(m_busy),    32'd0);
        check("rst_done",    32'(m_done),    32'd0);
        check("rst_pass",    32'(m_pass),    32'd0);
        check("rst_err",     32'(m_err),     32'd0);
        check("rst_first",   32'(m_first),   32'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int k;
        sel = 1'b0; rst_n = 1'b0; start = 1'b0; init_done = 1'b0; wr_full = 1'b0;

        // Reset held for 200 cycles; outputs checked mid-reset.
        repeat (5) @(negedge clk);
        check_reset_vals();
        while (cyc < 200) @(negedge clk);
        rst_n = 1'b1;

        // Nominal run: Start at 210, Init_done at 400, no pushes before it.
        while (cyc < 210) @(negedge clk);
        issue(16'h0000, N0);
        early = 0;
        while (cyc < 400) begin
            if (m_wr_en) early++;
            @(negedge clk);
        end
        check("no_push_before_init", 32'(early), 32'd0);
        init_done = 1'b1;
        wait_done(6000);

        // Corrupted words 37 and 500.
        corrupt.push_back(37);
        corrupt.push_back(500);
        issue(16'h0000, N0);
        check("restart_done_clr",  32'(m_done),  32'd0);
        check("restart_pass_clr",  32'(m_pass),  32'd0);
        check("restart_err_clr",   32'(m_err),   32'd0);
        check("restart_first_clr", 32'(m_first), 32'hFFFF);
        wait_done(6000);
        corrupt.delete();

        // Backpressure: Wr_full for 50 cycles mid-write, stray Start ignored,
        // Rd_empty toggling every cycle during the read phase.
        toggle_en = 1'b1;
        issue(16'h0000, N0);
        check("restart_err_clr2",   32'(m_err),   32'd0);
        check("restart_first_clr2", 32'(m_first), 32'hFFFF);
        k = 0;
        while (mon_pushes < 300 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("push_wait", 32'(mon_pushes >= 300), 32'd1);
        wr_full = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (49) @(negedge clk);
        wr_full = 1'b0;
        wait_done(8000);
        toggle_en = 1'b0;

        // Wrapping ramp on the short instance.
        sel = 1'b1;
        @(negedge clk);
        issue(SEED1, N1);
        wait_done(200);
        sel = 1'b0;
        @(negedge clk);

        // Reset pulse during READ aborts; a fresh run then passes.
        issue(16'h0000, N0);
        k = 0;
        while (mon_pops < 100 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check("pop_wait", 32'(mon_pops >= 100), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        check("abort_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        exp_res.delete();
        @(negedge clk);
        issue(16'h0000, N0);
        wait_done(6000);

        check("final_wr_queue",  32'(exp_wr.size()),  32'd0);
        check("final_res_queue", 32'(exp_res.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_traffic_checker.md
Name: sdram_traffic_checker

Overview:
- Synthesizable user-side partner for sdram_control_top. Drives the write-FIFO port with a deterministic pattern, then drains the read-FIFO port and checks every word.
- Used for on-board self-test and as the stimulus/check engine in controller regressions.
- Runs on one clock. Clk feeds the controller's Wr_clk and Rd_clk in this configuration.

Parameters:
- DSIZE, 16: data width; must match the controller.
- NUM_WORDS, 1000: words written, then read back (1..65535).
- SEED, 0: value of word 0; word i = (SEED + i) mod 2^DSIZE.
- DRAIN_CYCLES, 2000: Clk cycles between the last write and the first read, so the controller can flush the write FIFO to SDRAM.

Ports:
- Clk, in, 1: system clock; all logic on its rising edge.
- Rst_n, in, 1: reset; synchronous, active-low.
- Start, in, 1: one-cycle pulse; begins a test. Sampled only in IDLE or DONE.
- Init_done, in, 1: SDRAM init complete, from the controller.
- Wr_full, in, 1: write FIFO full.
- Wr_en, out, 1: write FIFO push.
- Wr_data, out, DSIZE: write FIFO data.
- Wr_load, out, 1: write FIFO/address reload (clear).
- Rd_empty, in, 1: read FIFO empty.
- Rd_en, out, 1: read FIFO pop.
- Rd_data, in, DSIZE: read FIFO data; valid the cycle after Rd_en (non-show-ahead FIFO).
- Rd_load, out, 1: read FIFO/address reload (clear).
- Busy, out, 1: high from Start accepted until DONE.
- Done, out, 1: level; high in DONE.
- Pass, out, 1: valid when Done; 1 iff Err_cnt==0.
- Err_cnt, out, 16: mismatch count; saturates at 16'hFFFF.
- First_err_idx, out, 16: index of the first mismatch; 16'hFFFF if none.

Behaviour:
- Reset values: Wr_en=0, Wr_data=0, Wr_load=1, Rd_en=0, Rd_load=1, Busy=0, Done=0, Pass=0, Err_cnt=0, First_err_idx=16'hFFFF. State=IDLE; all counters 0.
- Reset asserted mid-test aborts immediately to these values; no partial state survives.
- IDLE: Wr_load=Rd_load=0. On Start go to LOAD.
- DONE: behaves as IDLE. On Start, clear Done, Pass and the error registers in that same edge, then go to LOAD.
- LOAD: exactly 2 cycles with Wr_load=Rd_load=1. Index and error registers cleared. Then go to WAIT_INIT.
- WAIT_INIT: hold until Init_done=1, then go to WRITE.
- WRITE:
  - Wr_en = !Wr_full && (wr_idx < NUM_WORDS), registered from the state of the previous cycle.
  - Wr_data = SEED + wr_idx on the same cycle Wr_en is high.
  - wr_idx increments only on cycles with Wr_en=1.
  - No push ever occurs while Wr_full=1 as seen the cycle before.
  - When wr_idx==NUM_WORDS, Wr_en=0 and go to DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then go to READ.
- READ:
  - Rd_en = !Rd_empty && (rd_idx < NUM_WORDS).
  - rd_idx increments per Rd_en.
  - 1-cycle delayed pipeline: chk_valid and chk_idx are Rd_en and rd_idx delayed by one cycle.
  - When chk_valid: compare Rd_data with SEED+chk_idx (DSIZE-bit wrap).
  - On mismatch: Err_cnt+1 (saturating). First_err_idx is written only while it still equals 16'hFFFF.
  - When rd_idx==NUM_WORDS, go to CHECK_TAIL.
- CHECK_TAIL: one cycle, so the final compare completes. Then go to DONE with Done=1, Busy=0, Pass=(Err_cnt==0).
- No timeout: a stalled FIFO holds the FSM in WRITE or READ indefinitely.
- Start outside IDLE/DONE is ignored.
- Data wrap: with DSIZE=16, SEED=16'hFFFE, words are FFFE, FFFF, 0000, ...
- Busy = state not in {IDLE, DONE}.

Test Plan:
1. Reset 200 cycles; Start at cycle 210; Init_done at 400 -> Wr_load/Rd_load high exactly 2 cycles; first Wr_en at or after cycle 401 with Wr_data=0; 1000 pushes carrying 0..999.
2. Behavioural loopback FIFO (write FIFO wired to read FIFO), NUM_WORDS=1000 -> Done=1, Pass=1, Err_cnt=0, First_err_idx=FFFF; exactly 1000 Rd_en pulses.
3. Corrupt word 37 (bit 0 flipped) and word 500 in the loopback -> Err_cnt=2, First_err_idx=37, Pass=0.
4. Wr_full forced high for 50 cycles mid-write, Rd_empty toggled every cycle during read -> no push while full, no pop while empty; sequence stays contiguous; Pass=1.
5. SEED=16'hFFFE, NUM_WORDS=4 -> Wr_data FFFE, FFFF, 0000, 0001; Pass=1.
6. Rst_n low for 1 cycle during READ -> next cycle all outputs at reset values, state IDLE; a new Start runs a clean test with Pass=1.
